// File: rtl/ecap5_dproc_pkg.sv
// rtl/ecap5_dproc_pkg.sv - shared types and constants for the ECAP5-DPROC pipeline
package ecap5_dproc_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 1 << REG_ADDR_W;

   typedef enum logic {HAZM_RUN, HAZM_FLUSH} hazm_state_t;

   function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
      return {{(NUM_REGS-1){1'b0}}, 1'b1} << addr;
   endfunction

endpackage

// File: rtl/hazm_scoreboard.sv
// rtl/hazm_scoreboard.sv - pending-destination bitmap with same-cycle retire bypass mask
module hazm_scoreboard
   import ecap5_dproc_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  retire_valid_i,
   input  logic [REG_ADDR_W-1:0] retire_addr_i,
   input  logic                  set_en_i,
   input  logic [REG_ADDR_W-1:0] set_addr_i,
   output logic [NUM_REGS-1:0]   pending_o,
   output logic [NUM_REGS-1:0]   eff_o
);

   logic [NUM_REGS-1:0] pending;
   logic [NUM_REGS-1:0] clr_mask;
   logic [NUM_REGS-1:0] set_mask;
   logic [NUM_REGS-1:0] pending_next;

   always_comb begin
      clr_mask = retire_valid_i ? reg_onehot(retire_addr_i) : '0;
      set_mask = set_en_i ? reg_onehot(set_addr_i) : '0;
      eff_o    = pending & ~clr_mask;
      // Set is applied after clear so a same-register set/clear leaves the bit set.
      pending_next    = (pending & ~clr_mask) | set_mask;
      pending_next[0] = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pending <= '0;
      end else begin
         pending <= pending_next;
      end
   end

   assign pending_o = pending;

endmodule

// File: rtl/hazm.sv
// rtl/hazm.sv - decode-stage RAW/WAW hazard stall and taken-branch flush sequencer
module hazm
   import ecap5_dproc_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  dec_valid_i,
   input  logic [REG_ADDR_W-1:0] dec_rs1_i,
   input  logic                  dec_uses_rs1_i,
   input  logic [REG_ADDR_W-1:0] dec_rs2_i,
   input  logic                  dec_uses_rs2_i,
   input  logic [REG_ADDR_W-1:0] dec_rd_i,
   input  logic                  dec_reg_write_i,
   input  logic                  dec_issue_i,
   input  logic                  retire_valid_i,
   input  logic [REG_ADDR_W-1:0] retire_addr_i,
   input  logic                  branch_taken_i,
   output logic                  stall_o,
   output logic                  flush_o,
   output logic [NUM_REGS-1:0]   pending_o
);

   localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FLUSH_CYCLES - 1);

   hazm_state_t         state;
   logic [CNT_W-1:0]    cnt;
   logic [NUM_REGS-1:0] eff;
   logic                rd_nonzero;
   logic                hazard;
   logic                set_en;

   assign rd_nonzero = (dec_rd_i != '0);
   // Issues during a flush are protocol violations and must not mark anything pending.
   assign set_en     = dec_issue_i & dec_reg_write_i & rd_nonzero & ~flush_o;

   hazm_scoreboard u_scoreboard (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .retire_valid_i (retire_valid_i),
      .retire_addr_i  (retire_addr_i),
      .set_en_i       (set_en),
      .set_addr_i     (dec_rd_i),
      .pending_o      (pending_o),
      .eff_o          (eff)
   );

   always_comb begin
      hazard = dec_valid_i &
               ((dec_uses_rs1_i & eff[dec_rs1_i]) |
                (dec_uses_rs2_i & eff[dec_rs2_i]) |
                (dec_reg_write_i & rd_nonzero & eff[dec_rd_i]));
      stall_o = hazard | flush_o | branch_taken_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state   <= HAZM_RUN;
         cnt     <= '0;
         flush_o <= 1'b0;
      end else begin
         case (state)
            HAZM_RUN: begin
               if (branch_taken_i) begin
                  state   <= HAZM_FLUSH;
                  cnt     <= CNT_RELOAD;
                  flush_o <= 1'b1;
               end
            end
            HAZM_FLUSH: begin
               if (branch_taken_i) begin
                  cnt <= CNT_RELOAD;
               end else if (cnt == '0) begin
                  state   <= HAZM_RUN;
                  flush_o <= 1'b0;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: begin
               state   <= HAZM_RUN;
               cnt     <= '0;
               flush_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hazm.sv
// tb/tb_hazm.sv - self-checking bench for hazm: vector table, corner sequences, random vs model
module tb_hazm;

   localparam int FC = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        dec_valid;
   logic [4:0]  dec_rs1;
   logic        dec_uses_rs1;
   logic [4:0]  dec_rs2;
   logic        dec_uses_rs2;
   logic [4:0]  dec_rd;
   logic        dec_reg_write;
   logic        dec_issue;
   logic        retire_valid;
   logic [4:0]  retire_addr;
   logic        branch_taken;
   logic        stall;
   logic        flush;
   logic [31:0] pending;

   int errors = 0;
   int checks = 0;

   bit model_pend[32];
   int flush_left;

   typedef struct {
      logic       valid;
      logic [4:0] rs1;
      logic       u1;
      logic [4:0] rs2;
      logic       u2;
      logic [4:0] rd;
      logic       rw;
      logic       issue;
      logic       rv;
      logic [4:0] ra;
      logic       br;
      logic       exp_stall;
      logic       exp_flush;
      logic [31:0] exp_pend;
   } vec_t;

   vec_t vecs[$];

   hazm #(.FLUSH_CYCLES(FC)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .dec_valid_i    (dec_valid),
      .dec_rs1_i      (dec_rs1),
      .dec_uses_rs1_i (dec_uses_rs1),
      .dec_rs2_i      (dec_rs2),
      .dec_uses_rs2_i (dec_uses_rs2),
      .dec_rd_i       (dec_rd),
      .dec_reg_write_i(dec_reg_write),
      .dec_issue_i    (dec_issue),
      .retire_valid_i (retire_valid),
      .retire_addr_i  (retire_addr),
      .branch_taken_i (branch_taken),
      .stall_o        (stall),
      .flush_o        (flush),
      .pending_o      (pending)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic valid, input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                               input logic rw, input logic issue, input logic rv,
                               input logic [4:0] ra, input logic br, input logic es,
                               input logic ef, input logic [31:0] ep);
      vec_t v;
      v.valid = valid; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.rd = rd;
      v.rw = rw; v.issue = issue; v.rv = rv; v.ra = ra; v.br = br;
      v.exp_stall = es; v.exp_flush = ef; v.exp_pend = ep;
      return v;
   endfunction

   task automatic drive_idle();
      dec_valid = 0; dec_rs1 = 0; dec_uses_rs1 = 0; dec_rs2 = 0; dec_uses_rs2 = 0;
      dec_rd = 0; dec_reg_write = 0; dec_issue = 0; retire_valid = 0; retire_addr = 0;
      branch_taken = 0;
   endtask

   task automatic drive_vec(input vec_t v);
      dec_valid = v.valid; dec_rs1 = v.rs1; dec_uses_rs1 = v.u1; dec_rs2 = v.rs2;
      dec_uses_rs2 = v.u2; dec_rd = v.rd; dec_reg_write = v.rw; dec_issue = v.issue;
      retire_valid = v.rv; retire_addr = v.ra; branch_taken = v.br;
   endtask

   function automatic logic [31:0] model_pending();
      logic [31:0] p = '0;
      for (int i = 1; i < 32; i++) p[i] = model_pend[i];
      return p;
   endfunction

   // Outstanding writes minus the one retiring right now decide the hazard.
   function automatic logic model_stall();
      bit busy[32];
      logic hz;
      busy = model_pend;
      if (retire_valid) busy[retire_addr] = 0;
      busy[0] = 0;
      hz = dec_valid && ((dec_uses_rs1 && busy[dec_rs1]) ||
                         (dec_uses_rs2 && busy[dec_rs2]) ||
                         (dec_reg_write && dec_rd != 0 && busy[dec_rd]));
      return hz || (flush_left > 0) || branch_taken;
   endfunction

   task automatic model_edge();
      bit in_flush;
      in_flush = (flush_left > 0);
      if (retire_valid) model_pend[retire_addr] = 0;
      if (dec_issue && dec_reg_write && dec_rd != 0 && !in_flush) model_pend[dec_rd] = 1;
      if (branch_taken) flush_left = FC;
      else if (flush_left > 0) flush_left--;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 32; i++) model_pend[i] = 0;
      flush_left = 0;
   endtask

   initial begin
      model_clear();
      drive_idle();
      rst_n = 0;
      #2;
      check("reset_flush", {31'd0, flush}, 32'd0);
      check("reset_pending", pending, 32'd0);
      check("reset_stall", {31'd0, stall}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1;

      //          valid rs1 u1 rs2 u2 rd rw is rv ra br  stall flush pend
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0,  0, 0, 32'h0));
      vecs.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 32'h20));
      vecs.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 1, 5, 0,  0, 0, 32'h20));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0,  0, 0, 32'h0));
      vecs.push_back(mk(1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0,  0, 0, 32'h0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1, 1, 1, 7, 0,  0, 0, 32'h0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h80));
      vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0,  1, 0, 32'h80));
      vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 1, 7, 0,  0, 0, 32'h80));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0,  0, 0, 32'h0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 32'h0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 32'h0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 1,  1, 1, 32'h0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 32'h0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 32'h0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0));

      foreach (vecs[i]) begin
         drive_vec(vecs[i]);
         #2;
         check($sformatf("vec%0d_stall", i), {31'd0, stall}, {31'd0, vecs[i].exp_stall});
         check($sformatf("vec%0d_flush", i), {31'd0, flush}, {31'd0, vecs[i].exp_flush});
         check($sformatf("vec%0d_pending", i), pending, vecs[i].exp_pend);
         @(posedge clk);
         model_edge();
         #1;
      end

      // Asynchronous reset while flushing with x9 pending.
      drive_idle();
      dec_valid = 1; dec_rd = 9; dec_reg_write = 1; dec_issue = 1;
      @(posedge clk); model_edge(); #1;
      drive_idle();
      branch_taken = 1;
      @(posedge clk); model_edge(); #1;
      drive_idle();
      #2;
      check("pre_rst_flush", {31'd0, flush}, 32'd1);
      check("pre_rst_pending", pending, 32'h200);
      rst_n = 0;
      #1;
      check("async_rst_flush", {31'd0, flush}, 32'd0);
      check("async_rst_pending", pending, 32'h0);
      check("rst_stall_idle", {31'd0, stall}, 32'd0);
      branch_taken = 1;
      #1;
      check("rst_stall_branch", {31'd0, stall}, 32'd1);
      branch_taken = 0;
      model_clear();
      @(posedge clk);
      #1 rst_n = 1;

      for (int c = 0; c < 600; c++) begin
         dec_valid     = ($urandom_range(0, 3) != 0);
         dec_rs1       = 5'($urandom_range(0, 7));
         dec_uses_rs1  = $urandom_range(0, 1);
         dec_rs2       = 5'($urandom_range(0, 7));
         dec_uses_rs2  = $urandom_range(0, 1);
         dec_rd        = 5'($urandom_range(0, 7));
         dec_reg_write = $urandom_range(0, 1);
         retire_valid  = ($urandom_range(0, 2) == 0);
         retire_addr   = 5'($urandom_range(0, 7));
         branch_taken  = ($urandom_range(0, 15) == 0);
         dec_issue     = 0;
         dec_issue     = dec_valid && !model_stall() && ($urandom_range(0, 1) == 1);
         #2;
         check($sformatf("rand%0d_stall", c), {31'd0, stall}, {31'd0, model_stall()});
         check($sformatf("rand%0d_flush", c), {31'd0, flush}, {31'd0, flush_left > 0});
         check($sformatf("rand%0d_pending", c), pending, model_pending());
         @(posedge clk);
         model_edge();
         #1;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
